// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display driver: captures a packed hex value and scans it
// across NUM_DIGITS digits that share one active-low segment bus.

module hex_display_scan_chk #(
   parameter int NUM_DIGITS       = 4,
   parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
   input logic                  clk,
   input logic                  reset_n,
   input logic [NUM_DIGITS-1:0] digit_en,
   input logic                  frame_done
);
   localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

   a_single_digit: assert property (@(posedge clk) disable iff (!reset_n)
      $onehot0(digit_en ^ EN_OFF));

   a_frame_pulse: assert property (@(posedge clk) disable iff (!reset_n)
      frame_done |=> !frame_done);
endmodule

module hex_display_scan #(
   parameter int NUM_DIGITS       = 4,
   parameter int REFRESH_DIV      = 50000,
   parameter int GUARD_CYCLES     = 2,
   parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [1:7]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PW    = $clog2(REFRESH_DIV);

   localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0]         GUARD_END  = PW'(GUARD_CYCLES);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] EN_OFF     = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};
   localparam logic [1:7]            SEG_OFF    = 7'b1111111;

   logic [4*NUM_DIGITS-1:0] value_r;
   logic [NUM_DIGITS-1:0]   dp_r;
   logic                    blank_r;
   logic [PW-1:0]           presc_r;
   logic [IDX_W-1:0]        idx_r;

   logic [1:7]              seg_r;
   logic                    dp_out_r;
   logic [NUM_DIGITS-1:0]   digit_en_r;
   logic                    frame_done_r;

   logic [NUM_DIGITS-1:0]   lz_s;
   logic                    zero_run_s;
   logic [3:0]              nib_s;
   logic [1:7]              seg_s;
   logic                    dp_s;
   logic [NUM_DIGITS-1:0]   en_s;

   // Standard hex font, active-low, bit order g..a
   function automatic logic [1:7] hex_font(input logic [3:0] nib);
      logic [1:7] f;
      case (nib)
         4'h0:    f = 7'b1000000;
         4'h1:    f = 7'b1111001;
         4'h2:    f = 7'b0100100;
         4'h3:    f = 7'b0110000;
         4'h4:    f = 7'b0011001;
         4'h5:    f = 7'b0010010;
         4'h6:    f = 7'b0000010;
         4'h7:    f = 7'b1111000;
         4'h8:    f = 7'b0000000;
         4'h9:    f = 7'b0010000;
         4'hA:    f = 7'b0001000;
         4'hB:    f = 7'b0000011;
         4'hC:    f = 7'b1000110;
         4'hD:    f = 7'b0100001;
         4'hE:    f = 7'b0000110;
         4'hF:    f = 7'b0001110;
         default: f = 7'b1111111;
      endcase
      return f;
   endfunction

   // Leading-zero map: bit k set when nibbles k..top are all zero; digit 0 always shown
   always_comb begin
      zero_run_s = 1'b1;
      lz_s       = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run_s = zero_run_s & (value_r[4*k +: 4] == 4'h0);
         lz_s[k]    = zero_run_s;
      end
      lz_s[0] = 1'b0;
   end

   // Decode of the digit addressed by the scan index, with guard blanking of enables
   always_comb begin
      nib_s = value_r[{idx_r, 2'b00} +: 4];
      if (blank_r && lz_s[idx_r]) begin
         seg_s = SEG_OFF;
      end else begin
         seg_s = hex_font(nib_s);
      end
      dp_s = ~dp_r[idx_r];
      en_s = EN_OFF;
      if (presc_r < GUARD_END) begin
         en_s = EN_OFF;
      end else begin
         en_s[idx_r] = ~DIGIT_ACTIVE_LOW;
      end
   end

   // Shadow capture, refresh prescaler, digit index and frame strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_r      <= '0;
         dp_r         <= '0;
         blank_r      <= 1'b0;
         presc_r      <= '0;
         idx_r        <= '0;
         frame_done_r <= 1'b0;
      end else begin
         if (load) begin
            value_r <= value;
            dp_r    <= dp_in;
            blank_r <= blank_lz;
         end
         if (!enable) begin
            presc_r      <= '0;
            idx_r        <= '0;
            frame_done_r <= 1'b0;
         end else if (presc_r == PRESC_LAST) begin
            presc_r <= '0;
            if (idx_r == IDX_LAST) begin
               idx_r        <= '0;
               frame_done_r <= 1'b1;
            end else begin
               idx_r        <= idx_r + IDX_W'(1);
               frame_done_r <= 1'b0;
            end
         end else begin
            presc_r      <= presc_r + PW'(1);
            frame_done_r <= 1'b0;
         end
      end
   end

   // Registered pin drivers; display goes dark the cycle after enable drops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_r      <= SEG_OFF;
         dp_out_r   <= 1'b1;
         digit_en_r <= EN_OFF;
      end else if (!enable) begin
         seg_r      <= SEG_OFF;
         dp_out_r   <= 1'b1;
         digit_en_r <= EN_OFF;
      end else begin
         seg_r      <= seg_s;
         dp_out_r   <= dp_s;
         digit_en_r <= en_s;
      end
   end

   assign seg        = seg_r;
   assign dp         = dp_out_r;
   assign digit_en   = digit_en_r;
   assign frame_done = frame_done_r;

   hex_display_scan_chk #(
      .NUM_DIGITS       (NUM_DIGITS),
      .DIGIT_ACTIVE_LOW (DIGIT_ACTIVE_LOW)
   ) u_chk (
      .clk        (clk),
      .reset_n    (reset_n),
      .digit_en   (digit_en),
      .frame_done (frame_done)
   );
endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: directed scenarios plus random traffic, every cycle
// compared against a slot-arithmetic reference model.

module tb_hex_display_scan;
   localparam int ND    = 4;
   localparam int DIV   = 4;
   localparam int GUARD = 1;
   localparam int FRAME = ND * DIV;

   localparam logic [6:0] FONT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          load;
   logic [15:0]   value;
   logic [3:0]    dp_in;
   logic          blank_lz;
   logic [1:7]    seg;
   logic          dp;
   logic [3:0]    digit_en;
   logic          frame_done;

   int checks   = 0;
   int failures = 0;

   // model state: cycles into the current scan, and shadow copies
   int            cnt;
   logic [15:0]   sh_val;
   logic [3:0]    sh_dp;
   logic          sh_blz;
   logic [6:0]    exp_seg;
   logic          exp_dp;
   logic [3:0]    exp_en;
   logic          exp_fd;

   always #5 clk = ~clk;

   hex_display_scan #(
      .NUM_DIGITS       (ND),
      .REFRESH_DIV      (DIV),
      .GUARD_CYCLES     (GUARD),
      .DIGIT_ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .dp         (dp),
      .digit_en   (digit_en),
      .frame_done (frame_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      cnt     = 0;
      sh_val  = 16'h0000;
      sh_dp   = 4'b0000;
      sh_blz  = 1'b0;
      exp_seg = 7'b1111111;
      exp_dp  = 1'b1;
      exp_en  = 4'b1111;
      exp_fd  = 1'b0;
   endtask

   task automatic model_edge();
      int         d;
      int         p;
      logic [3:0] nib;
      logic       blank;
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (enable) begin
         d       = (cnt / DIV) % ND;
         p       = cnt % DIV;
         nib     = 4'(sh_val >> (4 * d));
         blank   = sh_blz && (d != 0) && ((sh_val >> (4 * d)) == 16'h0000);
         exp_en  = (p < GUARD) ? 4'b1111 : ~(4'b0001 << d);
         exp_seg = blank ? 7'b1111111 : FONT[nib];
         exp_dp  = ~sh_dp[d];
         exp_fd  = (cnt % FRAME) == (FRAME - 1);
         cnt     = (cnt + 1) % FRAME;
      end else begin
         exp_en  = 4'b1111;
         exp_seg = 7'b1111111;
         exp_dp  = 1'b1;
         exp_fd  = 1'b0;
         cnt     = 0;
      end
      if (load) begin
         sh_val = value;
         sh_dp  = dp_in;
         sh_blz = blank_lz;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("seg", 32'(seg), 32'(exp_seg));
      check_eq("dp", 32'(dp), 32'(exp_dp));
      check_eq("digit_en", 32'(digit_en), 32'(exp_en));
      check_eq("frame_done", 32'(frame_done), 32'(exp_fd));
   endtask

   task automatic load_and_run(input logic [15:0] v, input logic [3:0] d, input logic b, input int n);
      value    = v;
      dp_in    = d;
      blank_lz = b;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      for (int i = 1; i < n; i++) tick();
   endtask

   initial begin
      int fd_count;
      int guard_cnt;
      logic [15:0] mask;
      reset_n  = 1'b0;
      enable   = 1'b0;
      load     = 1'b0;
      value    = 16'h0000;
      dp_in    = 4'b0000;
      blank_lz = 1'b0;
      model_reset();
      tick();
      tick();
      reset_n = 1'b1;

      // basic scan of 1234, counting frame strobes over four frames
      enable   = 1'b1;
      value    = 16'h1234;
      load     = 1'b1;
      fd_count = 0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         tick();
         load = 1'b0;
         if (frame_done) fd_count++;
      end
      check_eq("frame_count", 32'(fd_count), 32'd4);

      // font sweep
      for (int i = 0; i < 16; i++) load_and_run(16'(i * 16'h1111), 4'b0000, 1'b0, FRAME);

      // leading-zero blanking and decimal point
      load_and_run(16'h0050, 4'b0000, 1'b1, 2 * FRAME);
      load_and_run(16'h0000, 4'b0000, 1'b1, 2 * FRAME);
      load_and_run(16'hABCD, 4'b0100, 1'b0, 2 * FRAME);

      // mid-scan load in slot 2, then a 3-cycle disable
      guard_cnt = 0;
      while (((cnt / DIV) % ND) != 2 && guard_cnt < 2 * FRAME) begin
         tick();
         guard_cnt++;
      end
      check_eq("reach_slot2", 32'((cnt / DIV) % ND), 32'd2);
      load_and_run(16'h9999, 4'b0000, 1'b0, 2);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      enable = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) tick();

      // asynchronous reset mid-slot
      load_and_run(16'h7E5A, 4'b1010, 1'b0, 6);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_eq("rst_seg", 32'(seg), 32'h7F);
      check_eq("rst_dp", 32'(dp), 32'h1);
      check_eq("rst_digit_en", 32'(digit_en), 32'hF);
      check_eq("rst_frame_done", 32'(frame_done), 32'h0);
      tick();
      tick();
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) tick();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         enable = ($urandom_range(0, 15) != 0);
         load   = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       mask = 16'h000F;
            1:       mask = 16'h00FF;
            2:       mask = 16'h0FFF;
            default: mask = 16'hFFFF;
         endcase
         value    = 16'($urandom) & mask;
         dp_in    = 4'($urandom);
         blank_lz = 1'($urandom);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
